// File: rtl/spi_slave_apb_if.sv
// APB register-bus bundle for the SPI target: the bus master drives the request,
// the target returns read data.
interface spi_slave_apb_if;
    logic       apb_psel;
    logic [3:0] apb_paddr;
    logic       apb_pwrite;
    logic       apb_penable;
    logic [7:0] apb_pwdata;
    logic [7:0] apb_prdata;

    modport master (
        output apb_psel, apb_paddr, apb_pwrite, apb_penable, apb_pwdata,
        input  apb_prdata
    );

    modport slave (
        input  apb_psel, apb_paddr, apb_pwrite, apb_penable, apb_pwdata,
        output apb_prdata
    );
endinterface

// File: rtl/spi_slave_apb.sv
// SPI target with APB registers: oversamples SCLK/CSN/MOSI in the pclk domain,
// shifts 8-bit MSB-first frames between small RX/TX FIFOs, modes 0-3.
module spi_slave_apb #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             apb_pclk,
    input  logic             apb_prstn,
    spi_slave_apb_if.slave   apb,
    input  logic             SPI_CLK,
    input  logic             SPI_CSN,
    input  logic             SPI_MOSI,
    output logic             SPI_MISO,
    output logic             SPI_MISO_OE,
    output logic             spi_int
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, csn_dly_q;

    state_t      state_q, state_d;
    logic        ie_q, ie_d, en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d;
    logic        rxif_q, rxif_d, txur_q, txur_d, rxov_q, rxov_d;
    logic [7:0]  shreg_q, shreg_d, rxsh_q, rxsh_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic        miso_q, miso_d, miso_oe_q, miso_oe_d, int_q, int_d;
    logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_q [FIFO_DEPTH];

    logic        sclk_s, csn_s, mosi_s, lead_edge, trail_edge, sample_edge, drive_edge;
    logic        csn_fall, csn_rise, wr_stb, rd_stb, w1c;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
    logic        load_now, rxif_set, txur_set, rxov_set;
    logic [7:0]  tx_head, rx_head, load_byte, rx_byte;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign csn_fall = csn_dly_q & ~csn_s;
    assign csn_rise = ~csn_dly_q & csn_s;

    // Edges are defined relative to the idle (cpol) level so one decoder covers all modes.
    assign lead_edge   = (sclk_dly_q == cpol_q) && (sclk_s != cpol_q);
    assign trail_edge  = (sclk_dly_q != cpol_q) && (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge  : trail_edge;

    assign wr_stb = apb.apb_psel & apb.apb_penable & apb.apb_pwrite;
    assign rd_stb = apb.apb_psel & apb.apb_penable & ~apb.apb_pwrite;
    assign w1c    = wr_stb && (apb.apb_paddr == 4'h1);

    assign tx_empty  = (tx_wptr_q == tx_rptr_q);
    assign rx_empty  = (rx_wptr_q == rx_rptr_q);
    assign tx_full   = ((tx_wptr_q - tx_rptr_q) == DEPTH_P);
    assign rx_full   = ((rx_wptr_q - rx_rptr_q) == DEPTH_P);
    assign tx_head   = tx_mem_q[tx_rptr_q[AW-1:0]];
    assign rx_head   = rx_mem_q[rx_rptr_q[AW-1:0]];
    assign load_byte = tx_empty ? 8'hFF : tx_head;
    assign rx_byte   = {rxsh_q[6:0], mosi_s};

    always_comb begin
        state_d   = state_q;
        ie_d      = ie_q;
        en_d      = en_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        shreg_d   = shreg_q;
        rxsh_d    = rxsh_q;
        bcnt_d    = bcnt_q;
        miso_d    = miso_q;
        load_now  = 1'b0;
        rxif_set  = 1'b0;
        txur_set  = 1'b0;
        rxov_set  = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        tx_push   = wr_stb && (apb.apb_paddr == 4'h2) && !tx_full && en_q;
        rx_pop    = rd_stb && (apb.apb_paddr == 4'h2) && !rx_empty;

        if (state_q != IDLE && csn_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (csn_fall) state_d = LOAD;
                LOAD: begin
                    load_now = 1'b1;
                    state_d  = ACTIVE;
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        rxsh_d = rx_byte;
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            rx_push  = !rx_full;
                            rxov_set = rx_full;
                            rxif_set = 1'b1;
                            load_now = 1'b1;
                        end
                    end else if (drive_edge) begin
                        // First drive edge of a byte presents bit7; later ones advance the shifter.
                        if (bcnt_q == 3'd0) begin
                            miso_d = shreg_q[7];
                        end else begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            miso_d  = shreg_q[6];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load_now) begin
            shreg_d  = load_byte;
            tx_pop   = !tx_empty;
            txur_set = tx_empty;
            bcnt_d   = 3'd0;
            if (!cpha_q) miso_d = load_byte[7];
        end

        rxif_d    = (rxif_q & ~(w1c & apb.apb_pwdata[7])) | rxif_set;
        txur_d    = (txur_q & ~(w1c & apb.apb_pwdata[6])) | txur_set;
        rxov_d    = (rxov_q & ~(w1c & apb.apb_pwdata[5])) | rxov_set;
        tx_wptr_d = tx_wptr_q + (AW+1)'(tx_push);
        tx_rptr_d = tx_rptr_q + (AW+1)'(tx_pop);
        rx_wptr_d = rx_wptr_q + (AW+1)'(rx_push);
        rx_rptr_d = rx_rptr_q + (AW+1)'(rx_pop);
        miso_oe_d = en_q & ~csn_s;
        int_d     = ie_q & (rxif_q | txur_q | rxov_q);

        // A disabled block is held in its idle, empty state.
        if (!en_q) begin
            state_d   = IDLE;
            shreg_d   = 8'h00;
            rxsh_d    = 8'h00;
            bcnt_d    = 3'd0;
            miso_d    = 1'b1;
            rxif_d    = 1'b0;
            txur_d    = 1'b0;
            rxov_d    = 1'b0;
            rx_push   = 1'b0;
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            rx_wptr_d = '0;
            rx_rptr_d = '0;
        end

        if (wr_stb && apb.apb_paddr == 4'h0) begin
            ie_d   = apb.apb_pwdata[7];
            en_d   = apb.apb_pwdata[6];
            cpol_d = apb.apb_pwdata[3];
            cpha_d = apb.apb_pwdata[2];
        end
    end

    always_comb begin
        case (apb.apb_paddr)
            4'h0:    apb.apb_prdata = {ie_q, en_q, 2'b00, cpol_q, cpha_q, 2'b00};
            4'h1:    apb.apb_prdata = {rxif_q, txur_q, rxov_q, state_q != IDLE,
                                       tx_full, tx_empty, rx_full, rx_empty};
            4'h2:    apb.apb_prdata = rx_empty ? 8'h00 : rx_head;
            default: apb.apb_prdata = 8'h00;
        endcase
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            csn_dly_q   <= 1'b1;
            state_q     <= IDLE;
            ie_q        <= 1'b0;
            en_q        <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            rxif_q      <= 1'b0;
            txur_q      <= 1'b0;
            rxov_q      <= 1'b0;
            shreg_q     <= 8'h00;
            rxsh_q      <= 8'h00;
            bcnt_q      <= 3'd0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            int_q       <= 1'b0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], SPI_CSN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_dly_q  <= sclk_s;
            csn_dly_q   <= csn_s;
            state_q     <= state_d;
            ie_q        <= ie_d;
            en_q        <= en_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            rxif_q      <= rxif_d;
            txur_q      <= txur_d;
            rxov_q      <= rxov_d;
            shreg_q     <= shreg_d;
            rxsh_q      <= rxsh_d;
            bcnt_q      <= bcnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            int_q       <= int_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
        end
    end

    // FIFO storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge apb_pclk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= apb.apb_pwdata;
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_byte;
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_OE = miso_oe_q;
    assign spi_int     = int_q;
endmodule

// File: tb/tb_spi_slave_apb.sv
// Directed bench for spi_slave_apb: behavioural SPI master plus APB tasks,
// each expected value worked out by hand from the register map.
module tb_spi_slave_apb;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SPI_CLK = 1'b0, SPI_CSN = 1'b1, SPI_MOSI = 1'b0;
    logic SPI_MISO, SPI_MISO_OE, spi_int;
    logic m_cpol = 1'b0, m_cpha = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rd, rx;

    spi_slave_apb_if apb_bus ();

    spi_slave_apb #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .apb_pclk    (clk),
        .apb_prstn   (rst_n),
        .apb         (apb_bus),
        .SPI_CLK     (SPI_CLK),
        .SPI_CSN     (SPI_CSN),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .spi_int     (spi_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%02h", tag, got);
        end
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        apb_bus.apb_psel = 1'b1; apb_bus.apb_pwrite = 1'b1;
        apb_bus.apb_paddr = addr; apb_bus.apb_pwdata = data; apb_bus.apb_penable = 1'b0;
        @(negedge clk);
        apb_bus.apb_penable = 1'b1;
        @(negedge clk);
        apb_bus.apb_psel = 1'b0; apb_bus.apb_penable = 1'b0; apb_bus.apb_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [7:0] data);
        @(negedge clk);
        apb_bus.apb_psel = 1'b1; apb_bus.apb_pwrite = 1'b0;
        apb_bus.apb_paddr = addr; apb_bus.apb_penable = 1'b0;
        @(negedge clk);
        apb_bus.apb_penable = 1'b1;
        #1 data = apb_bus.apb_prdata;
        @(negedge clk);
        apb_bus.apb_psel = 1'b0; apb_bus.apb_penable = 1'b0;
    endtask

    task automatic spi_start();
        SPI_CSN = 1'b0;
        #(HALF);
    endtask

    task automatic spi_stop();
        #(HALF);
        SPI_CSN = 1'b1;
        #(HALF);
    endtask

    // Shifts nbits MSB-first; master samples MISO on its sample edge.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!m_cpha) begin
                SPI_MOSI = tx[i];
                #(HALF);
                rxb[i] = SPI_MISO;
                SPI_CLK = ~m_cpol;
                #(HALF);
                SPI_CLK = m_cpol;
            end else begin
                #(HALF);
                SPI_CLK = ~m_cpol;
                SPI_MOSI = tx[i];
                #(HALF);
                rxb[i] = SPI_MISO;
                SPI_CLK = m_cpol;
            end
        end
    endtask

    initial begin
        apb_bus.apb_psel = 1'b0; apb_bus.apb_penable = 1'b0; apb_bus.apb_pwrite = 1'b0;
        apb_bus.apb_paddr = 4'h0; apb_bus.apb_pwdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_miso", {7'd0, SPI_MISO}, 8'h01);
        check("rst_oe", {7'd0, SPI_MISO_OE}, 8'h00);
        check("rst_int", {7'd0, spi_int}, 8'h00);
        apb_read(4'h0, rd); check("rst_ctrl", rd, 8'h00);
        apb_read(4'h1, rd); check("rst_stat", rd, 8'h05);
        apb_read(4'h7, rd); check("unmapped", rd, 8'h00);

        // Mode 0: TX 0xA5 out, 0x3C in
        apb_write(4'h0, 8'hC0);
        apb_write(4'h2, 8'hA5);
        apb_read(4'h1, rd); check("m0_stat_tx", rd, 8'h01);
        spi_start();
        check("m0_oe", {7'd0, SPI_MISO_OE}, 8'h01);
        spi_xfer(8'h3C, 8, rx);
        spi_stop();
        check("m0_master_rx", rx, 8'hA5);
        check("m0_int", {7'd0, spi_int}, 8'h01);
        apb_read(4'h1, rd); check("m0_stat", rd, 8'hC4);
        apb_read(4'h2, rd); check("m0_data", rd, 8'h3C);
        apb_write(4'h1, 8'hE0);
        repeat (3) @(negedge clk);
        apb_read(4'h1, rd); check("m0_stat_clr", rd, 8'h05);
        check("m0_int_clr", {7'd0, spi_int}, 8'h00);

        // Mode 3: four back-to-back bytes, then an overflowing fifth
        apb_write(4'h0, 8'h4C);
        m_cpol = 1'b1; m_cpha = 1'b1; SPI_CLK = 1'b1;
        repeat (6) @(negedge clk);
        spi_start();
        for (int b = 1; b <= 4; b++) begin
            spi_xfer(8'(b), 8, rx);
            check($sformatf("m3_miso_ff%0d", b), rx, 8'hFF);
        end
        #(HALF);
        apb_read(4'h1, rd); check("m3_stat_full", rd, 8'hD6);
        spi_xfer(8'h05, 8, rx);
        #(HALF);
        apb_read(4'h1, rd); check("m3_stat_ov", rd, 8'hF6);
        apb_write(4'h1, 8'h20);
        apb_read(4'h1, rd); check("m3_stat_ovclr", rd, 8'hD6);
        spi_stop();
        apb_read(4'h1, rd); check("m3_stat_idle", rd, 8'hC6);
        for (int b = 1; b <= 4; b++) begin
            apb_read(4'h2, rd);
            check($sformatf("m3_data%0d", b), rd, 8'(b));
        end
        apb_read(4'h1, rd); check("m3_stat_empty", rd, 8'hC5);
        apb_write(4'h1, 8'hE0);

        // Mode 0: aborted 5-bit frame, then a full 0x81 frame
        apb_write(4'h0, 8'h40);
        m_cpol = 1'b0; m_cpha = 1'b0; SPI_CLK = 1'b0;
        repeat (6) @(negedge clk);
        spi_start();
        spi_xfer(8'hF8, 5, rx);
        spi_stop();
        apb_read(4'h1, rd); check("part_stat", rd, 8'h45);
        spi_start();
        spi_xfer(8'h81, 8, rx);
        spi_stop();
        check("full_master_rx", rx, 8'hFF);
        apb_read(4'h1, rd); check("full_stat", rd, 8'hC4);
        apb_read(4'h2, rd); check("full_data", rd, 8'h81);
        apb_read(4'h2, rd); check("full_data_empty", rd, 8'h00);
        apb_read(4'h1, rd); check("full_stat_empty", rd, 8'hC5);

        // Asynchronous reset in the middle of a frame
        apb_write(4'h0, 8'hC0);
        repeat (3) @(negedge clk);
        check("pre_rst_int", {7'd0, spi_int}, 8'h01);
        apb_write(4'h2, 8'h5A);
        spi_start();
        spi_xfer(8'h00, 2, rx);
        repeat (6) @(negedge clk);
        check("pre_rst_miso", {7'd0, SPI_MISO}, 8'h00);
        check("pre_rst_oe", {7'd0, SPI_MISO_OE}, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        check("arst_miso", {7'd0, SPI_MISO}, 8'h01);
        check("arst_oe", {7'd0, SPI_MISO_OE}, 8'h00);
        check("arst_int", {7'd0, spi_int}, 8'h00);
        SPI_CSN = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        apb_read(4'h0, rd); check("post_rst_ctrl", rd, 8'h00);
        apb_read(4'h1, rd); check("post_rst_stat", rd, 8'h05);
        apb_write(4'h0, 8'h40);
        apb_write(4'h2, 8'h96);
        spi_start();
        spi_xfer(8'h42, 8, rx);
        spi_stop();
        check("post_rst_master_rx", rx, 8'h96);
        apb_read(4'h2, rd); check("post_rst_data", rd, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
